multi_step_counter: RTL and testbench
=====================================

Name: multi_step_counter

Overview:
- Parametrised, multi-channel address/phase counter for the signal generator; successor to the single-channel enable counter.
- Each of NCH channels advances by its own per-cycle increment under a shared mode: wrap up, wrap down, saturate or bounce.
- Counts run modulo a programmable ceiling, and each channel raises a wrap pulse at its boundary.
- Sits between control inputs (rotary/vbd values) and the waveform ROM address ports.

Parameters:
- WIDTH, 8, bit width of each count, increment and load value.
- NCH, 2, number of independent channels.
- MAX_VAL, 2**WIDTH-1, inclusive upper count limit; counts live in [0, MAX_VAL]. Legal range is 1 to 2**WIDTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- en  in  NCH  per-channel count enable.
- incr  in  NCH*WIDTH  per-channel step; channel i uses bits [i*WIDTH +: WIDTH].
- mode  in  2  shared mode: 00 wrap-up, 01 wrap-down, 10 saturate-up, 11 bounce.
- ld  in  NCH  per-channel synchronous load strobe.
- ld_val  in  WIDTH  load value, shared by all channels.
- count  out  NCH*WIDTH  registered per-channel count.
- wrap  out  NCH  registered one-cycle boundary pulse, aligned with the count update.
- dir  out  NCH  bounce direction: 1 = up, 0 = down.

Behaviour:
- Reset: on a clk edge with rst=0, all count=0, wrap=0 and dir=1, regardless of en, ld or mode.
- Latency: all outputs are registered; count updates 1 cycle after en is sampled high.
- Per-channel priority: rst > ld > en. No enable means hold, with wrap=0.
- Load: count <= min(ld_val, MAX_VAL) and wrap=0. dir is unchanged.
- Effective step s = min(incr_i, MAX_VAL). Internal arithmetic uses WIDTH+1 bits, so there is no silent overflow.
- s=0 with en=1: count holds and wrap=0 in every mode.
- Wrap-up (00): t = count+s. If t > MAX_VAL, count <= t-(MAX_VAL+1) and wrap=1; otherwise count <= t.
- Wrap-down (01): if count < s, count <= count+(MAX_VAL+1)-s and wrap=1; otherwise count <= count-s.
- Saturate-up (10): count <= min(count+s, MAX_VAL).
  - wrap=1 only on the cycle count transitions from below MAX_VAL to MAX_VAL.
  - Holding at MAX_VAL gives wrap=0.
- Bounce (11), dir=1:
  - t = count+s.
  - If t >= MAX_VAL: count <= MAX_VAL-(t-MAX_VAL), dir <= 0, wrap=1.
  - Otherwise count <= t.
- Bounce (11), dir=0:
  - If count <= s: count <= s-count, dir <= 1, wrap=1.
  - Otherwise count <= count-s.
- The reflected bounce result is always within [0, MAX_VAL] because s <= MAX_VAL.
- dir changes only in bounce mode or on reset.
- Mode change mid-run: the new mode applies from the next enabled update, starting from the current count. Entering bounce uses the retained dir.
- Channels are fully independent except for the shared mode and ld_val.
- Reset mid-operation overrides any pending load or step on that edge.

Optional Feature:
- Macro: MULTI_STEP_COUNTER_PHASE_OFS_EN.
- When defined:
  - Adds input phase_ofs (WIDTH) and output count_ofs (NCH*WIDTH).
  - count_ofs_i = (count_i + min(phase_ofs, MAX_VAL)) mod (MAX_VAL+1), combinational from the registered count; no extra latency.
  - Used for quadrature/phase-shifted ROM reads.
- When undefined: both ports are absent and the behaviour is otherwise identical.

Test Plan:
- Reset: rst=0 for 2 cycles with en=all 1, ld=all 1, incr=5 -> count=0, wrap=0, dir=1. Release rst; en=1 -> count=5 one cycle later.
- Wrap-up: MAX_VAL=255, mode=00, incr=100 from 0 -> counts 100, 200, 44. wrap=1 only with 44.
- Wrap-down and saturate, MAX_VAL=255:
  - mode=01, ld_val=1 loaded, incr=3 -> 254 with wrap=1, then 251.
  - mode=10, incr=100 from 0 -> 100, 200, 255, 255. wrap=1 only at the first 255.
- Bounce: MAX_VAL=9, mode=11, incr=4 from 0 -> counts 4, 8, 6, 2, 2, 6.
  - dir goes 1, 1, 0, 0, 1, 1.
  - wrap=1 on the 6 (first turn) and on the second 2.
- Priority and edges:
  - ld=1 and en=1 same cycle, ld_val=300 with WIDTH=9, MAX_VAL=255 -> count=255, wrap=0.
  - incr=0, en=1 -> count holds, wrap=0.
  - incr=300 (WIDTH=9), mode=00, MAX_VAL=255 -> step clamped to 255.
  - Channel 1 disabled while channel 0 counts -> channel 1 holds.
- With MULTI_STEP_COUNTER_PHASE_OFS_EN: MAX_VAL=255, count=200, phase_ofs=64 -> count_ofs=8, in the same cycle as count.

Source files
------------

// File: rtl/multi_step_counter.sv
// multi_step_counter
//   Multi-channel address/phase counter for the signal generator. Each of NCH
//   channels advances by its own step under a shared mode (wrap-up, wrap-down,
//   saturate-up, bounce) inside [0, MAX_VAL], pulsing wrap at its boundary.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active low
//   en         in   [NCH]        per-channel count enable
//   incr       in   [NCH*WIDTH]  per-channel step, channel i at [i*WIDTH +: WIDTH]
//   mode       in   [2]          00 wrap-up, 01 wrap-down, 10 saturate-up, 11 bounce
//   ld         in   [NCH]        per-channel synchronous load strobe
//   ld_val     in   [WIDTH]      shared load value
//   count      out  [NCH*WIDTH]  registered counts
//   wrap       out  [NCH]        registered boundary pulse, aligned with count
//   dir        out  [NCH]        bounce direction, 1 = up
//   phase_ofs  in   [WIDTH]      (MULTI_STEP_COUNTER_PHASE_OFS_EN only) phase offset
//   count_ofs  out  [NCH*WIDTH]  (MULTI_STEP_COUNTER_PHASE_OFS_EN only) offset counts
//
// Optional feature macro: MULTI_STEP_COUNTER_PHASE_OFS_EN

module multi_step_counter_lane #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] incr_i,
  input  logic [1:0]       mode_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
`ifdef MULTI_STEP_COUNTER_PHASE_OFS_EN
  input  logic [WIDTH-1:0] ofs_i,
  output logic [WIDTH-1:0] count_ofs_o,
`endif
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o,
  output logic             dir_o
);
  // One extra bit of headroom keeps every sum/difference exact.
  localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] MODV = MAXV + 1'b1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             dir_q, dir_d;
  logic [WIDTH:0]   s, c, t, nxt;

  always_comb begin
    s       = ({1'b0, incr_i} > MAXV) ? MAXV : {1'b0, incr_i};
    c       = {1'b0, count_q};
    t       = c + s;
    nxt     = c;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    count_d = count_q;
    if (ld_i) begin
      count_d = ({1'b0, ld_val_i} > MAXV) ? MAXV[WIDTH-1:0] : ld_val_i;
    end else if (en_i && (s != '0)) begin
      // A zero step is a pure hold in every mode, so no reflection or pulse.
      unique case (mode_i)
        2'b00: begin
          if (t > MAXV) begin nxt = t - MODV; wrap_d = 1'b1; end
          else            nxt = t;
        end
        2'b01: begin
          if (c < s) begin nxt = c + MODV - s; wrap_d = 1'b1; end
          else           nxt = c - s;
        end
        2'b10: begin
          nxt    = (t > MAXV) ? MAXV : t;
          // Pulse only on arrival at the ceiling, not while parked there.
          wrap_d = (c < MAXV) && (t >= MAXV);
        end
        2'b11: begin
          if (dir_q) begin
            if (t >= MAXV) begin nxt = MAXV - (t - MAXV); dir_d = 1'b0; wrap_d = 1'b1; end
            else                 nxt = t;
          end else begin
            if (c <= s) begin nxt = s - c; dir_d = 1'b1; wrap_d = 1'b1; end
            else            nxt = c - s;
          end
        end
      endcase
      count_d = nxt[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      dir_q   <= dir_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;
  assign dir_o   = dir_q;

`ifdef MULTI_STEP_COUNTER_PHASE_OFS_EN
  logic [WIDTH:0] ofs_c, ofs_sum;
  always_comb begin
    ofs_c   = ({1'b0, ofs_i} > MAXV) ? MAXV : {1'b0, ofs_i};
    ofs_sum = c + ofs_c;
    if (ofs_sum > MAXV) ofs_sum = ofs_sum - MODV;
    count_ofs_o = ofs_sum[WIDTH-1:0];
  end
`endif
endmodule

module multi_step_counter #(
  parameter int WIDTH   = 8,
  parameter int NCH     = 2,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH*WIDTH-1:0] incr,
  input  logic [1:0]           mode,
  input  logic [NCH-1:0]       ld,
  input  logic [WIDTH-1:0]     ld_val,
  output logic [NCH*WIDTH-1:0] count,
  output logic [NCH-1:0]       wrap,
  output logic [NCH-1:0]       dir
`ifdef MULTI_STEP_COUNTER_PHASE_OFS_EN
  ,
  input  logic [WIDTH-1:0]     phase_ofs,
  output logic [NCH*WIDTH-1:0] count_ofs
`endif
);
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    multi_step_counter_lane #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en[i]),
      .incr_i     (incr[i*WIDTH +: WIDTH]),
      .mode_i     (mode),
      .ld_i       (ld[i]),
      .ld_val_i   (ld_val),
`ifdef MULTI_STEP_COUNTER_PHASE_OFS_EN
      .ofs_i      (phase_ofs),
      .count_ofs_o(count_ofs[i*WIDTH +: WIDTH]),
`endif
      .count_o    (count[i*WIDTH +: WIDTH]),
      .wrap_o     (wrap[i]),
      .dir_o      (dir[i])
    );
  end
endmodule

// File: tb/tb_multi_step_counter.sv
// Testbench for multi_step_counter: table-driven vectors on a 9-bit/255 build,
// a bounce sequence on a 4-bit/9 build, then random stimulus on both against
// an arithmetic reference model.
module tb_multi_step_counter;
  localparam int NCH = 2;
  localparam int WA = 9, MA = 255;
  localparam int WB = 4, MB = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              a_rst, b_rst;
  logic [NCH-1:0]    a_en, a_ld, b_en, b_ld, a_wrap, b_wrap, a_dir, b_dir;
  logic [NCH*WA-1:0] a_incr, a_cnt;
  logic [NCH*WB-1:0] b_incr, b_cnt;
  logic [1:0]        a_mode, b_mode;
  logic [WA-1:0]     a_ldv;
  logic [WB-1:0]     b_ldv;
`ifdef MULTI_STEP_COUNTER_PHASE_OFS_EN
  logic [WA-1:0]     a_po;
  logic [WB-1:0]     b_po;
  logic [NCH*WA-1:0] a_co;
  logic [NCH*WB-1:0] b_co;
`endif

  multi_step_counter #(.WIDTH(WA), .NCH(NCH), .MAX_VAL(MA)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .incr(a_incr), .mode(a_mode), .ld(a_ld),
    .ld_val(a_ldv), .count(a_cnt), .wrap(a_wrap), .dir(a_dir)
`ifdef MULTI_STEP_COUNTER_PHASE_OFS_EN
    , .phase_ofs(a_po), .count_ofs(a_co)
`endif
  );

  multi_step_counter #(.WIDTH(WB), .NCH(NCH), .MAX_VAL(MB)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .incr(b_incr), .mode(b_mode), .ld(b_ld),
    .ld_val(b_ldv), .count(b_cnt), .wrap(b_wrap), .dir(b_dir)
`ifdef MULTI_STEP_COUNTER_PHASE_OFS_EN
    , .phase_ofs(b_po), .count_ofs(b_co)
`endif
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: one update of one channel, from the rules in plain integers.
  function automatic void mstep(input int M, input bit r, input bit e, input bit l,
                                input int inc, input int md, input int lv,
                                inout int c, inout bit d, output bit w);
    int s;
    w = 1'b0;
    if (!r) begin c = 0; d = 1'b1; return; end
    if (l) begin c = (lv > M) ? M : lv; return; end
    if (!e) return;
    s = (inc > M) ? M : inc;
    if (s == 0) return;
    case (md)
      0: begin w = (c + s > M); c = (c + s) % (M + 1); end
      1: begin w = (c < s); c = (c - s + M + 1) % (M + 1); end
      2: begin w = (c < M) && (c + s >= M); c = (c + s > M) ? M : c + s; end
      default:
        if (d) begin
          if (c + s >= M) begin c = 2*M - (c + s); d = 1'b0; w = 1'b1; end
          else c = c + s;
        end else begin
          if (c <= s) begin c = s - c; d = 1'b1; w = 1'b1; end
          else c = c - s;
        end
    endcase
  endfunction

  typedef struct {
    bit rst; bit [1:0] en; bit [1:0] ld; int inc0; int inc1; bit [1:0] mode; int ldv;
    int c0; int c1; bit [1:0] w; bit [1:0] d;
  } vec_t;
  vec_t tv[$];

  int ma_c[NCH], mb_c[NCH];
  bit ma_d[NCH], mb_d[NCH], wtmp;
  int be_c[6] = '{4, 8, 6, 2, 2, 6};
  bit be_d[6] = '{1, 1, 0, 0, 1, 1};
  bit be_w[6] = '{0, 0, 1, 0, 1, 0};

  initial begin
    a_rst = 1'b0; a_en = '0; a_ld = '0; a_incr = '0; a_mode = 2'd0; a_ldv = '0;
    b_rst = 1'b0; b_en = '0; b_ld = '0; b_incr = '0; b_mode = 2'd0; b_ldv = '0;
`ifdef MULTI_STEP_COUNTER_PHASE_OFS_EN
    a_po = '0; b_po = '0;
`endif
    //                rst  en     ld     i0   i1   mode  ldv  c0   c1   w      d
    tv.push_back('{1'b0, 2'b11, 2'b11,   5,   5, 2'd0,   0,   0,   0, 2'b00, 2'b11});
    tv.push_back('{1'b0, 2'b11, 2'b11,   5,   5, 2'd0,   0,   0,   0, 2'b00, 2'b11});
    tv.push_back('{1'b1, 2'b11, 2'b00,   5,   5, 2'd0,   0,   5,   5, 2'b00, 2'b11});
    tv.push_back('{1'b1, 2'b00, 2'b11,   5,   5, 2'd0,   0,   0,   0, 2'b00, 2'b11});
    tv.push_back('{1'b1, 2'b01, 2'b00, 100, 100, 2'd0,   0, 100,   0, 2'b00, 2'b11});
    tv.push_back('{1'b1, 2'b01, 2'b00, 100, 100, 2'd0,   0, 200,   0, 2'b00, 2'b11});
    tv.push_back('{1'b1, 2'b01, 2'b00, 100, 100, 2'd0,   0,  44,   0, 2'b01, 2'b11});
    tv.push_back('{1'b1, 2'b01, 2'b00, 100, 100, 2'd0,   0, 144,   0, 2'b00, 2'b11});
    tv.push_back('{1'b1, 2'b11, 2'b01,   3, 100, 2'd1,   1,   1, 156, 2'b10, 2'b11});
    tv.push_back('{1'b1, 2'b01, 2'b00,   3, 100, 2'd1,   1, 254, 156, 2'b01, 2'b11});
    tv.push_back('{1'b1, 2'b01, 2'b00,   3, 100, 2'd1,   1, 251, 156, 2'b00, 2'b11});
    tv.push_back('{1'b1, 2'b00, 2'b11,   3, 100, 2'd1,   0,   0,   0, 2'b00, 2'b11});
    tv.push_back('{1'b1, 2'b11, 2'b00, 100, 100, 2'd2,   0, 100, 100, 2'b00, 2'b11});
    tv.push_back('{1'b1, 2'b11, 2'b00, 100, 100, 2'd2,   0, 200, 200, 2'b00, 2'b11});
    tv.push_back('{1'b1, 2'b11, 2'b00, 100, 100, 2'd2,   0, 255, 255, 2'b11, 2'b11});
    tv.push_back('{1'b1, 2'b11, 2'b00, 100, 100, 2'd2,   0, 255, 255, 2'b00, 2'b11});
    tv.push_back('{1'b1, 2'b11, 2'b11, 100, 100, 2'd2, 300, 255, 255, 2'b00, 2'b11});
    tv.push_back('{1'b1, 2'b11, 2'b00,   0, 300, 2'd0,   0, 255, 254, 2'b10, 2'b11});
    tv.push_back('{1'b1, 2'b11, 2'b00,   0, 300, 2'd0,   0, 255, 253, 2'b10, 2'b11});
    tv.push_back('{1'b0, 2'b11, 2'b11,   7,   7, 2'd0,   9,   0,   0, 2'b00, 2'b11});

    for (int k = 0; k < tv.size(); k++) begin
      a_rst = tv[k].rst; a_en = tv[k].en; a_ld = tv[k].ld; a_mode = tv[k].mode;
      a_incr = {WA'(tv[k].inc1), WA'(tv[k].inc0)}; a_ldv = WA'(tv[k].ldv);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count0", k), int'(a_cnt[0 +: WA]), tv[k].c0);
      chk($sformatf("vec%0d_count1", k), int'(a_cnt[WA +: WA]), tv[k].c1);
      chk($sformatf("vec%0d_wrap", k), int'(a_wrap), int'(tv[k].w));
      chk($sformatf("vec%0d_dir", k), int'(a_dir), int'(tv[k].d));
    end

`ifdef MULTI_STEP_COUNTER_PHASE_OFS_EN
    // Offset output is combinational from the registered count.
    a_rst = 1'b1; a_en = '0; a_ld = 2'b01; a_ldv = WA'(200); a_po = WA'(64);
    @(posedge clk); #1;
    chk("phase_ofs_count", int'(a_cnt[0 +: WA]), 200);
    chk("phase_ofs_out", int'(a_co[0 +: WA]), 8);
    a_ld = '0; a_po = WA'(300);
    #1;
    chk("phase_ofs_clamp", int'(a_co[0 +: WA]), (200 + 255) % 256);
`endif

    // Bounce on a 0..9 range, channel 1 idle.
    b_rst = 1'b0; @(posedge clk); #1;
    chk("b_reset_count", int'(b_cnt), 0);
    chk("b_reset_dir", int'(b_dir), 3);
    b_rst = 1'b1; b_mode = 2'd3; b_en = 2'b01; b_incr = {4'd0, 4'd4};
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bounce%0d_count", k), int'(b_cnt[0 +: WB]), be_c[k]);
      chk($sformatf("bounce%0d_dir", k), int'(b_dir), int'({1'b1, be_d[k]}));
      chk($sformatf("bounce%0d_wrap", k), int'(b_wrap), int'({1'b0, be_w[k]}));
      chk($sformatf("bounce%0d_ch1", k), int'(b_cnt[WB +: WB]), 0);
    end
    // Step 15 clamps to 9; load of 15 clamps to 9.
    b_mode = 2'd0; b_en = '0; b_ld = 2'b01; b_ldv = '0;
    @(posedge clk); #1;
    b_ld = '0; b_en = 2'b01; b_incr = {4'd0, 4'd15};
    @(posedge clk); #1;
    chk("b_clamp_step1", int'(b_cnt[0 +: WB]), 9);
    chk("b_clamp_wrap1", int'(b_wrap), 0);
    @(posedge clk); #1;
    chk("b_clamp_step2", int'(b_cnt[0 +: WB]), 8);
    chk("b_clamp_wrap2", int'(b_wrap), 1);
    b_ld = 2'b10; b_ldv = 4'd15; b_en = '0;
    @(posedge clk); #1;
    chk("b_clamp_load", int'(b_cnt[WB +: WB]), 9);

    // Random phase against the model.
    a_rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NCH; i++) begin
      ma_c[i] = 0; ma_d[i] = 1'b1; mb_c[i] = 0; mb_d[i] = 1'b1;
    end
    for (int n = 0; n < 600; n++) begin
      bit [NCH-1:0] wa, wb;
      a_rst = ($urandom_range(0, 60) != 0); b_rst = ($urandom_range(0, 60) != 0);
      a_en = NCH'($urandom); b_en = NCH'($urandom);
      a_ld = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      b_ld = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      a_incr = (NCH*WA)'($urandom); b_incr = (NCH*WB)'($urandom);
      if ($urandom_range(0, 9) == 0) a_mode = 2'($urandom);
      if ($urandom_range(0, 9) == 0) b_mode = 2'($urandom);
      a_ldv = WA'($urandom); b_ldv = WB'($urandom);
`ifdef MULTI_STEP_COUNTER_PHASE_OFS_EN
      a_po = WA'($urandom); b_po = WB'($urandom);
`endif
      for (int i = 0; i < NCH; i++) begin
        mstep(MA, a_rst, a_en[i], a_ld[i], int'(a_incr[i*WA +: WA]), int'(a_mode),
              int'(a_ldv), ma_c[i], ma_d[i], wtmp);
        wa[i] = wtmp;
        mstep(MB, b_rst, b_en[i], b_ld[i], int'(b_incr[i*WB +: WB]), int'(b_mode),
              int'(b_ldv), mb_c[i], mb_d[i], wtmp);
        wb[i] = wtmp;
      end
      @(posedge clk); #1;
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("rnd%0d_a_count%0d", n, i), int'(a_cnt[i*WA +: WA]), ma_c[i]);
        chk($sformatf("rnd%0d_a_dir%0d", n, i), int'(a_dir[i]), int'(ma_d[i]));
        chk($sformatf("rnd%0d_b_count%0d", n, i), int'(b_cnt[i*WB +: WB]), mb_c[i]);
        chk($sformatf("rnd%0d_b_dir%0d", n, i), int'(b_dir[i]), int'(mb_d[i]));
`ifdef MULTI_STEP_COUNTER_PHASE_OFS_EN
        chk($sformatf("rnd%0d_a_ofs%0d", n, i), int'(a_co[i*WA +: WA]),
            (ma_c[i] + ((int'(a_po) > MA) ? MA : int'(a_po))) % (MA + 1));
        chk($sformatf("rnd%0d_b_ofs%0d", n, i), int'(b_co[i*WB +: WB]),
            (mb_c[i] + ((int'(b_po) > MB) ? MB : int'(b_po))) % (MB + 1));
`endif
      end
      chk($sformatf("rnd%0d_a_wrap", n), int'(a_wrap), int'(wa));
      chk($sformatf("rnd%0d_b_wrap", n), int'(b_wrap), int'(wb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
